// File: rtl/mic_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS captured config words and optionally reads them back.
// Define MIC_SEQ_READBACK_EN to add the read-back verification pass (RD/RDATA states).
module mic_cfg_sequencer #(
    parameter int          NUM_REGS   = 4,
    parameter int          ADDR_WIDTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic [NUM_REGS*32-1:0]  cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [3:0]              err_idx,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [31:0]             M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [31:0]             M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

`ifdef MIC_SEQ_READBACK_EN
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, WR, WRESP, FIN} state_t;
`endif

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    state_t                 state;
    logic [3:0]             idx;
    logic [NUM_REGS*32-1:0] cfg_q;

    assign M_AXI_WSTRB = 4'hF;

    function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [3:0] i);
        logic [31:0] a;
        a = BASE_ADDR + {26'd0, i, 2'b00};
        return a[ADDR_WIDTH-1:0];
    endfunction

    function automatic logic [31:0] word_of(input logic [3:0] i);
        return cfg_q[32*i +: 32];
    endfunction

    // NOTE: cfg_q is plain data only consulted while a run is active, so it needs no reset.
    always_ff @(posedge ACLK) begin
        if (state == IDLE && start)
            cfg_q <= cfg_data;
    end

    // NOTE: all state updates use <= so every decision below sees the pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state         <= IDLE;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_idx       <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
`ifdef MIC_SEQ_READBACK_EN
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx           <= '0;
                        err           <= 1'b0;
                        err_idx       <= '0;
                        busy          <= 1'b1;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                        M_AXI_AWADDR  <= addr_of(4'd0);
                        M_AXI_WDATA   <= cfg_data[31:0];
                        state         <= WR;
                    end
                end
                WR: begin
                    // A channel whose VALID is already low finished its handshake earlier.
                    if (M_AXI_AWVALID && M_AXI_AWREADY)
                        M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WVALID && M_AXI_WREADY)
                        M_AXI_WVALID <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) begin
                            err     <= 1'b1;
                            err_idx <= idx;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (idx == LAST_IDX) begin
`ifdef MIC_SEQ_READBACK_EN
                            idx           <= '0;
                            M_AXI_ARVALID <= 1'b1;
                            M_AXI_ARADDR  <= addr_of(4'd0);
                            state         <= RD;
`else
                            done  <= 1'b1;
                            state <= FIN;
`endif
                        end else begin
                            idx           <= idx + 4'd1;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            M_AXI_AWADDR  <= addr_of(idx + 4'd1);
                            M_AXI_WDATA   <= word_of(idx + 4'd1);
                            state         <= WR;
                        end
                    end
                end
`ifdef MIC_SEQ_READBACK_EN
                RD: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RDATA;
                    end
                end
                RDATA: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != word_of(idx)) begin
                            err     <= 1'b1;
                            err_idx <= idx;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx           <= idx + 4'd1;
                            M_AXI_ARVALID <= 1'b1;
                            M_AXI_ARADDR  <= addr_of(idx + 4'd1);
                            state         <= RD;
                        end
                    end
                end
`endif
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef MIC_SEQ_READBACK_EN
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RRESP, M_AXI_RDATA};
`endif

endmodule
